lii_stream_packer: RTL and testbench

- Kernel-to-LII egress packer.
- Gathers narrow KW-bit words from an HLS kernel output stream and packs WPB = PW/KW of them into one PW-bit LII phy beat.
- Tags each beat with fixed src/dst IDs; supports a partial-beat flush on kernel tlast.
- Sits between an HLS kernel's output AXI-stream and an LII phy output channel; it is the transmit-side counterpart of the unpacking done in the kernel wrappers.

---
 rtl/lii_pkg.sv | 29 ++
 rtl/lii_out_reg.sv | 46 ++++
 rtl/lii_stream_packer.sv | 133 +++++++++++++
 tb/tb_lii_stream_packer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lii_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lii_pkg
// Description : Shared LII egress definitions: ID width, default beat layout
//               and the helper that sizes the word-count field.
// Revision    : 1.0 - initial release
// ============================================================================
package lii_pkg;

    localparam int LII_ID_W   = 8;
    localparam int LII_DEF_KW = 32;
    localparam int LII_DEF_PW = 128;

    // Width of a field able to hold the values 0..wpb inclusive.
    function automatic int lii_nw_width(input int wpb);
        return $clog2(wpb + 1);
    endfunction

    localparam int LII_DEF_NW = lii_nw_width(LII_DEF_PW / LII_DEF_KW);

    // Beat layout for the default 32-bit kernel / 128-bit phy configuration.
    typedef struct packed {
        logic [LII_DEF_PW-1:0] data;
        logic                  last;
        logic [LII_DEF_NW-1:0] nwords;
    } lii_beat_t;

endpackage
`default_nettype wire

// File: rtl/lii_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : lii_out_reg
// Description : One-entry valid/ready output register for LII egress blocks.
//               Accepts a new payload whenever empty or draining this cycle,
//               holds the payload stable while stalled.
// Revision    : 1.0 - initial release
// ============================================================================
module lii_out_reg
    import lii_pkg::*;
#(
    parameter int WIDTH = $bits(lii_beat_t)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // The slot is free when empty or when its current content leaves this edge.
    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // Load on upstream transfer, otherwise drop valid once downstream takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_valid && o_ready) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lii_stream_packer.sv
`default_nettype none
// ============================================================================
// Module      : lii_stream_packer
// Description : Kernel-to-LII egress packer. Gathers KW-bit kernel words into
//               PW-bit phy beats (word i in bits [i*KW +: KW]), flushes a
//               partial beat on kernel tlast, tags beats with fixed IDs.
// Revision    : 1.0 - initial release
// ============================================================================
module lii_stream_packer
    import lii_pkg::*;
#(
    parameter int                   KW     = 32,
    parameter int                   PW     = 128,
    parameter logic [LII_ID_W-1:0]  SRC_ID = 8'h00,
    parameter logic [LII_ID_W-1:0]  DST_ID = 8'h01,
    localparam int                  NW     = lii_nw_width(PW / KW)
) (
    input  logic                aclk,
    input  logic                arstn,
    input  logic [KW-1:0]       in_stream_tdata,
    input  logic                in_stream_tvalid,
    output logic                in_stream_tready,
    input  logic                in_stream_tlast,
    output logic [PW-1:0]       lii_out_p0_tdata,
    output logic                lii_out_p0_tvalid,
    input  logic                lii_out_p0_tready,
    output logic                lii_out_p0_tlast,
    output logic [NW-1:0]       lii_out_p0_nwords,
    output logic [LII_ID_W-1:0] lii_out_p0_src,
    output logic [LII_ID_W-1:0] lii_out_p0_dst
);

    localparam int c_wpb   = PW / KW;
    localparam int c_idx_w = (c_wpb > 1) ? $clog2(c_wpb) : 1;
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(c_wpb - 1);

    typedef struct packed {
        logic [PW-1:0] data;
        logic          last;
        logic [NW-1:0] nwords;
    } beat_t;

    if (PW % KW != 0) begin : g_cfg_check
        $error("lii_stream_packer: PW must be a multiple of KW");
    end

    logic [PW-1:0]      r_acc;
    logic [c_idx_w-1:0] r_idx;
    logic               r_acc_full;
    logic               r_acc_last;
    logic [NW-1:0]      r_acc_n;

    logic               w_out_free;
    logic               w_out_valid;
    logic               w_xfer;
    logic               w_hs;
    logic               w_complete;
    logic [PW-1:0]      w_acc_next;
    logic [PW-1:0]      w_pad_data;
    beat_t              w_beat_in;
    beat_t              w_beat_out;

    // A completed accumulator moves to the output register whenever it has room.
    assign w_xfer           = r_acc_full && w_out_free;
    assign in_stream_tready = !r_acc_full || w_xfer;
    assign w_hs             = in_stream_tvalid && in_stream_tready;
    assign w_complete       = w_hs && ((r_idx == c_idx_last) || in_stream_tlast);

    // Next accumulator image: cleared when handed off, then the new word lands
    // in its lane (lane 0 whenever the hand-off happens this cycle).
    always_comb begin
        w_acc_next = w_xfer ? '0 : r_acc;
        if (w_hs) begin
            w_acc_next[int'(r_idx) * KW +: KW] = in_stream_tdata;
        end
    end

    // Accumulator, lane index and completed-beat bookkeeping.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_acc      <= '0;
            r_idx      <= '0;
            r_acc_full <= 1'b0;
            r_acc_last <= 1'b0;
            r_acc_n    <= '0;
        end else begin
            r_acc <= w_acc_next;
            if (w_complete) begin
                r_acc_full <= 1'b1;
                r_acc_last <= in_stream_tlast;
                r_acc_n    <= NW'(r_idx) + NW'(1);
                r_idx      <= '0;
            end else begin
                if (w_xfer) begin
                    r_acc_full <= 1'b0;
                end
                if (w_hs) begin
                    r_idx <= r_idx + c_idx_w'(1);
                end
            end
        end
    end

    // Lanes beyond the word count are forced to zero in the emitted beat.
    for (genvar gi = 0; gi < c_wpb; gi++) begin : g_lane
        assign w_pad_data[gi*KW +: KW] =
            (NW'(gi) < r_acc_n) ? r_acc[gi*KW +: KW] : '0;
    end

    assign w_beat_in = '{data: w_pad_data, last: r_acc_last, nwords: r_acc_n};

    lii_out_reg #(
        .WIDTH ($bits(beat_t))
    ) u_out_reg (
        .clk     (aclk),
        .rst_n   (arstn),
        .i_valid (r_acc_full),
        .o_ready (w_out_free),
        .i_data  (w_beat_in),
        .o_valid (w_out_valid),
        .i_ready (lii_out_p0_tready),
        .o_data  (w_beat_out)
    );

    assign lii_out_p0_tvalid = w_out_valid;
    assign lii_out_p0_tdata  = w_beat_out.data;
    assign lii_out_p0_tlast  = w_beat_out.last;
    assign lii_out_p0_nwords = w_beat_out.nwords;
    assign lii_out_p0_src    = SRC_ID;
    assign lii_out_p0_dst    = DST_ID;

endmodule
`default_nettype wire

// File: tb/tb_lii_stream_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lii_stream_packer
// Description : Self-checking bench for lii_stream_packer with a word-queue
//               reference model, expected-beat scoreboard and monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lii_stream_packer;

    localparam int KW  = 32;
    localparam int PW  = 128;
    localparam int WPB = PW / KW;
    localparam int NW  = 3;

    logic          aclk  = 1'b0;
    logic          arstn = 1'b0;
    logic [KW-1:0] in_stream_tdata;
    logic          in_stream_tvalid;
    logic          in_stream_tready;
    logic          in_stream_tlast;
    logic [PW-1:0] lii_out_p0_tdata;
    logic          lii_out_p0_tvalid;
    logic          lii_out_p0_tready;
    logic          lii_out_p0_tlast;
    logic [NW-1:0] lii_out_p0_nwords;
    logic [7:0]    lii_out_p0_src;
    logic [7:0]    lii_out_p0_dst;

    always #5 aclk = ~aclk;

    lii_stream_packer #(
        .KW     (KW),
        .PW     (PW),
        .SRC_ID (8'h00),
        .DST_ID (8'h01)
    ) dut (
        .aclk              (aclk),
        .arstn             (arstn),
        .in_stream_tdata   (in_stream_tdata),
        .in_stream_tvalid  (in_stream_tvalid),
        .in_stream_tready  (in_stream_tready),
        .in_stream_tlast   (in_stream_tlast),
        .lii_out_p0_tdata  (lii_out_p0_tdata),
        .lii_out_p0_tvalid (lii_out_p0_tvalid),
        .lii_out_p0_tready (lii_out_p0_tready),
        .lii_out_p0_tlast  (lii_out_p0_tlast),
        .lii_out_p0_nwords (lii_out_p0_nwords),
        .lii_out_p0_src    (lii_out_p0_src),
        .lii_out_p0_dst    (lii_out_p0_dst)
    );

    typedef struct {
        logic [PW-1:0] data;
        logic          last;
        logic [NW-1:0] nw;
    } exp_t;

    exp_t          exp_q[$];
    logic [KW-1:0] pend[$];
    int            n_checks   = 0;
    int            n_fail     = 0;
    int            ready_mode = 1;   // 0: hold low, 1: hold high, 2: random
    int            beats_seen = 0;
    int            cyc        = 0;
    int            last_wait  = 0;

    function automatic void check(input string nm, input logic [PW-1:0] act,
                                  input logic [PW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Reference model: collect words, emit a beat at WPB words or on tlast.
    function automatic void model_word(input logic [KW-1:0] d, input logic l);
        exp_t e;
        pend.push_back(d);
        if (pend.size() == WPB || l) begin
            e.data = '0;
            foreach (pend[i]) e.data[i*KW +: KW] = pend[i];
            e.nw   = NW'(pend.size());
            e.last = l;
            exp_q.push_back(e);
            pend.delete();
        end
    endfunction

    always @(posedge aclk) cyc <= cyc + 1;

    // Downstream ready driver.
    initial begin
        lii_out_p0_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            case (ready_mode)
                0:       lii_out_p0_tready = 1'b0;
                1:       lii_out_p0_tready = 1'b1;
                default: lii_out_p0_tready = ($urandom_range(0, 1) == 1);
            endcase
        end
    end

    // Monitor: every presented beat must equal the scoreboard head.
    initial begin
        forever begin
            @(negedge aclk);
            if (arstn && lii_out_p0_tvalid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got data %h with no beat expected",
                             lii_out_p0_tdata);
                end else begin
                    check("beat_data", lii_out_p0_tdata, exp_q[0].data);
                    check("beat_nwords", PW'(lii_out_p0_nwords), PW'(exp_q[0].nw));
                    check("beat_last", PW'(lii_out_p0_tlast), PW'(exp_q[0].last));
                    if (lii_out_p0_tready) begin
                        void'(exp_q.pop_front());
                        beats_seen++;
                    end
                end
            end
        end
    end

    task automatic send_word(input logic [KW-1:0] d, input logic l);
        logic ok;
        int   waited;
        waited = 0;
        ok     = 1'b0;
        in_stream_tdata  = d;
        in_stream_tlast  = l;
        in_stream_tvalid = 1'b1;
        while (!ok && waited < 1000) begin
            @(negedge aclk);
            ok = in_stream_tready;
            @(posedge aclk);
            #1;
            waited++;
        end
        last_wait = waited;
        if (ok) begin
            model_word(d, l);
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: word %h not accepted after %0d cycles, required acceptance",
                     d, waited);
        end
        in_stream_tvalid = 1'b0;
        in_stream_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge aclk);
            n++;
        end
        #1;
        check("drain", PW'(exp_q.size()), '0);
    endtask

    // Watchdog.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int bs0;
        in_stream_tdata  = '0;
        in_stream_tvalid = 1'b0;
        in_stream_tlast  = 1'b0;

        // Reset state.
        arstn = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_tvalid", PW'(lii_out_p0_tvalid), '0);
        check("rst_tdata", lii_out_p0_tdata, '0);
        check("rst_tlast", PW'(lii_out_p0_tlast), '0);
        check("rst_nwords", PW'(lii_out_p0_nwords), '0);
        @(posedge aclk);
        #1 arstn = 1'b1;
        @(negedge aclk);
        check("rst_in_tready", PW'(in_stream_tready), PW'(1));
        check("src_id", PW'(lii_out_p0_src), PW'(8'h00));
        check("dst_id", PW'(lii_out_p0_dst), PW'(8'h01));
        @(posedge aclk);
        #1;

        // Full beat.
        for (int i = 1; i <= 4; i++) send_word({8{4'(i)}}, 1'b0);
        wait_drain();

        // Partial flush.
        send_word(32'h0000000A, 1'b0);
        send_word(32'h0000000B, 1'b1);
        wait_drain();

        // tlast on lane 0.
        send_word(32'h0000C0DE, 1'b1);
        wait_drain();

        // Throughput with ready held high.
        t0 = cyc;
        for (int i = 0; i < 8; i++) send_word($urandom, (i == 7));
        check("throughput_cycles", PW'(cyc - t0), PW'(8));
        wait_drain();

        // Backpressure.
        ready_mode = 0;
        @(posedge aclk);
        #2;
        bs0 = beats_seen;
        for (int i = 1; i <= 8; i++) send_word(32'hB000_0000 + i, 1'b0);
        @(negedge aclk);
        check("bp_in_tready_low", PW'(in_stream_tready), '0);
        fork
            begin
                for (int i = 9; i <= 12; i++) send_word(32'hB000_0000 + i, 1'b0);
            end
            begin
                repeat (10) @(posedge aclk);
                @(negedge aclk);
                check("bp_in_tready_held", PW'(in_stream_tready), '0);
                ready_mode = 1;
            end
        join
        wait_drain();
        check("bp_beat_count", PW'(beats_seen - bs0), PW'(3));

        // Random streaming.
        ready_mode = 2;
        for (int i = 0; i < 400; i++) begin
            send_word($urandom, (i % 7 == 6) || (i == 399));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge aclk);
                #1;
            end
        end
        ready_mode = 1;
        wait_drain();

        // Reset mid-frame.
        for (int i = 0; i < 3; i++) send_word(32'hDEAD_0000 + i, 1'b0);
        arstn = 1'b0;
        pend.delete();
        exp_q.delete();
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        check("midrst_tvalid", PW'(lii_out_p0_tvalid), '0);
        @(posedge aclk);
        #1 arstn = 1'b1;
        repeat (5) @(posedge aclk);
        @(negedge aclk);
        check("midrst_no_beat", PW'(lii_out_p0_tvalid), '0);
        check("midrst_in_tready", PW'(in_stream_tready), PW'(1));
        @(posedge aclk);
        #1;
        bs0 = beats_seen;
        for (int i = 0; i < 4; i++) send_word(32'h5A5A_0000 + i, 1'b0);
        wait_drain();
        check("midrst_beat_count", PW'(beats_seen - bs0), PW'(1));

        repeat (5) @(posedge aclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
